// File: rtl/iahb_bus_decoder.sv
// Instruction-side AHB-lite decoder: memory/peripheral/default slave select and data-phase response mux.
// Optional IAHB_DEC_ERR_RESP_EN: unmapped transfers get a two-cycle AHB ERROR response instead of OKAY.
module iahb_bus_decoder #(
  parameter logic [15:0] MEM_BASE_HI = 16'h0000,
  parameter logic [15:0] PER_BASE_HI = 16'h4000
) (
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst_b,
  input  logic [31:0] cpu_haddr,
  input  logic [1:0]  cpu_htrans,
  input  logic [2:0]  cpu_hsize,
  input  logic        cpu_hwrite,
  input  logic [31:0] cpu_hwdata,
  output logic [31:0] cpu_hrdata,
  output logic        cpu_hready,
  output logic [1:0]  cpu_hresp,
  output logic [31:0] lite_yy_haddr,
  output logic [2:0]  lite_yy_hsize,
  output logic [1:0]  lite_yy_htrans,
  output logic        lite_yy_hwrite,
  output logic [31:0] lite_yy_hwdata,
  output logic        lite_mmc_hsel,
  input  logic [31:0] mmc_lite_hrdata,
  input  logic        mmc_lite_hready,
  input  logic [1:0]  mmc_lite_hresp,
  output logic        lite_per_hsel,
  input  logic [31:0] per_lite_hrdata,
  input  logic        per_lite_hready,
  input  logic [1:0]  per_lite_hresp,
  output logic [7:0]  dec_err_cnt
);

  typedef enum logic [1:0] {DSEL_NONE, DSEL_MEM, DSEL_PER, DSEL_DEF} dsel_t;

  dsel_t       dsel_q, dsel_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        accepted, mem_hit, per_hit, unmapped;

`ifdef IAHB_DEC_ERR_RESP_EN
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
  ds_state_t   ds_q, ds_d;
`endif

  assign lite_yy_haddr  = cpu_haddr;
  assign lite_yy_hsize  = cpu_hsize;
  assign lite_yy_htrans = cpu_htrans;
  assign lite_yy_hwrite = cpu_hwrite;
  assign lite_yy_hwdata = cpu_hwdata;

  // Slaves do not qualify hsel themselves, so only accepted NONSEQ/SEQ transfers select.
  assign accepted      = cpu_htrans[1] & cpu_hready;
  assign mem_hit       = (cpu_haddr[31:16] == MEM_BASE_HI);
  assign per_hit       = (cpu_haddr[31:16] == PER_BASE_HI);
  assign unmapped      = accepted & ~mem_hit & ~per_hit;
  assign lite_mmc_hsel = accepted & mem_hit;
  assign lite_per_hsel = accepted & per_hit & ~mem_hit;
  assign dec_err_cnt   = err_cnt_q;

  always_comb begin
    cpu_hrdata = 32'h0;
    cpu_hready = 1'b1;
    cpu_hresp  = 2'b00;
    case (dsel_q)
      DSEL_MEM: begin
        cpu_hrdata = mmc_lite_hrdata;
        cpu_hready = mmc_lite_hready;
        cpu_hresp  = mmc_lite_hresp;
      end
      DSEL_PER: begin
        cpu_hrdata = per_lite_hrdata;
        cpu_hready = per_lite_hready;
        cpu_hresp  = per_lite_hresp;
      end
      DSEL_DEF: begin
`ifdef IAHB_DEC_ERR_RESP_EN
        cpu_hready = (ds_q != DS_ERR1);
        cpu_hresp  = (ds_q == DS_IDLE) ? 2'b00 : 2'b01;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    dsel_d = dsel_q;
    if (cpu_hready) begin
      if (lite_mmc_hsel)      dsel_d = DSEL_MEM;
      else if (lite_per_hsel) dsel_d = DSEL_PER;
      else if (unmapped)      dsel_d = DSEL_DEF;
      else                    dsel_d = DSEL_NONE;
    end
    err_cnt_d = err_cnt_q;
    if (unmapped && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

`ifdef IAHB_DEC_ERR_RESP_EN
  // ERR1 stalls the bus, so an accepted transfer can only arrive from IDLE or ERR2.
  always_comb begin
    ds_d = ds_q;
    case (ds_q)
      DS_IDLE: if (unmapped) ds_d = DS_ERR1;
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = unmapped ? DS_ERR1 : DS_IDLE;
      default: ds_d = DS_IDLE;
    endcase
  end
`endif

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      dsel_q    <= DSEL_NONE;
      err_cnt_q <= 8'h00;
`ifdef IAHB_DEC_ERR_RESP_EN
      ds_q      <= DS_IDLE;
`endif
    end else begin
      dsel_q    <= dsel_d;
      err_cnt_q <= err_cnt_d;
`ifdef IAHB_DEC_ERR_RESP_EN
      ds_q      <= ds_d;
`endif
    end
  end

endmodule

// File: tb/tb_iahb_bus_decoder.sv
// Directed table-driven bench for iahb_bus_decoder; expectations follow IAHB_DEC_ERR_RESP_EN when defined.
`timescale 1ns/1ps
module tb_iahb_bus_decoder;

  localparam logic [31:0] MEM_DATA = 32'hCAFE_F00D;
  localparam logic [31:0] PER_DATA = 32'h1234_5678;
  localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] cpu_haddr, cpu_hwdata, cpu_hrdata;
  logic [1:0]  cpu_htrans, cpu_hresp;
  logic [2:0]  cpu_hsize;
  logic        cpu_hwrite, cpu_hready;
  logic [31:0] yy_haddr, yy_hwdata;
  logic [2:0]  yy_hsize;
  logic [1:0]  yy_htrans;
  logic        yy_hwrite;
  logic        mmc_hsel, per_hsel;
  logic [31:0] mmc_hrdata, per_hrdata;
  logic        mmc_hready, per_hready;
  logic [1:0]  mmc_hresp, per_hresp;
  logic [7:0]  cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iahb_bus_decoder dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst_b   (rst_b),
    .cpu_haddr       (cpu_haddr),
    .cpu_htrans      (cpu_htrans),
    .cpu_hsize       (cpu_hsize),
    .cpu_hwrite      (cpu_hwrite),
    .cpu_hwdata      (cpu_hwdata),
    .cpu_hrdata      (cpu_hrdata),
    .cpu_hready      (cpu_hready),
    .cpu_hresp       (cpu_hresp),
    .lite_yy_haddr   (yy_haddr),
    .lite_yy_hsize   (yy_hsize),
    .lite_yy_htrans  (yy_htrans),
    .lite_yy_hwrite  (yy_hwrite),
    .lite_yy_hwdata  (yy_hwdata),
    .lite_mmc_hsel   (mmc_hsel),
    .mmc_lite_hrdata (mmc_hrdata),
    .mmc_lite_hready (mmc_hready),
    .mmc_lite_hresp  (mmc_hresp),
    .lite_per_hsel   (per_hsel),
    .per_lite_hrdata (per_hrdata),
    .per_lite_hready (per_hready),
    .per_lite_hresp  (per_hresp),
    .dec_err_cnt     (cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        mmc_rdy;
    logic        e_msel;
    logic        e_psel;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] a, input logic [1:0] t, input logic mr,
                     input logic ms, input logic ps, input logic r,
                     input logic [1:0] rs, input logic [31:0] d, input logic [7:0] c);
    vec_t v;
    v.addr = a; v.trans = t; v.mmc_rdy = mr;
    v.e_msel = ms; v.e_psel = ps; v.e_rdy = r; v.e_resp = rs; v.e_rdata = d; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ms, input logic ps, input logic r,
                         input logic [1:0] rs, input logic [31:0] d, input logic [7:0] c);
    chk({tag, " mmc_hsel"}, {31'h0, mmc_hsel}, {31'h0, ms});
    chk({tag, " per_hsel"}, {31'h0, per_hsel}, {31'h0, ps});
    chk({tag, " hready"}, {31'h0, cpu_hready}, {31'h0, r});
    chk({tag, " hresp"}, {30'h0, cpu_hresp}, {30'h0, rs});
    chk({tag, " hrdata"}, cpu_hrdata, d);
    chk({tag, " cnt"}, {24'h0, cnt}, {24'h0, c});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0;
    cpu_haddr = 32'h0; cpu_htrans = T_IDLE; cpu_hsize = 3'b010; cpu_hwrite = 1'b0;
    cpu_hwdata = 32'h0;
    mmc_hrdata = MEM_DATA; mmc_hready = 1'b1; mmc_hresp = 2'b00;
    per_hrdata = PER_DATA; per_hready = 1'b1; per_hresp = 2'b00;

    //         addr          trans   mr  ms ps rdy resp   rdata     cnt
    add(32'h0000_0010, T_NS,   1, 1, 0, 1, 2'b00, 32'h0,    8'd0);
    add(32'h0000_0000, T_IDLE, 1, 0, 0, 1, 2'b00, MEM_DATA, 8'd0);
    add(32'h0000_0020, T_NS,   1, 1, 0, 1, 2'b00, 32'h0,    8'd0);
    add(32'h4000_0000, T_NS,   0, 0, 0, 0, 2'b00, MEM_DATA, 8'd0);
    add(32'h4000_0000, T_NS,   1, 0, 1, 1, 2'b00, MEM_DATA, 8'd0);
    add(32'h4000_0000, T_IDLE, 1, 0, 0, 1, 2'b00, PER_DATA, 8'd0);
    add(32'h4000_0004, T_NS,   1, 0, 1, 1, 2'b00, 32'h0,    8'd0);
    add(32'h0000_0030, T_NS,   1, 1, 0, 1, 2'b00, PER_DATA, 8'd0);
    add(32'h0000_0000, T_IDLE, 1, 0, 0, 1, 2'b00, MEM_DATA, 8'd0);
    add(32'h8000_0000, T_IDLE, 1, 0, 0, 1, 2'b00, 32'h0,    8'd0);
    add(32'h8000_0000, T_BUSY, 1, 0, 0, 1, 2'b00, 32'h0,    8'd0);
    add(32'h8000_0000, T_NS,   1, 0, 0, 1, 2'b00, 32'h0,    8'd0);
`ifdef IAHB_DEC_ERR_RESP_EN
    add(32'h0000_0040, T_NS,   1, 0, 0, 0, 2'b01, 32'h0,    8'd1);
    add(32'h8000_0004, T_NS,   1, 0, 0, 1, 2'b01, 32'h0,    8'd1);
    add(32'h0000_0000, T_IDLE, 1, 0, 0, 0, 2'b01, 32'h0,    8'd2);
    add(32'h0000_0000, T_IDLE, 1, 0, 0, 1, 2'b01, 32'h0,    8'd2);
    add(32'h0000_0000, T_IDLE, 1, 0, 0, 1, 2'b00, 32'h0,    8'd2);
`else
    add(32'h0000_0040, T_NS,   1, 1, 0, 1, 2'b00, 32'h0,    8'd1);
    add(32'h8000_0004, T_NS,   1, 0, 0, 1, 2'b00, MEM_DATA, 8'd1);
    add(32'h0000_0000, T_IDLE, 1, 0, 0, 1, 2'b00, 32'h0,    8'd2);
    add(32'h0000_0000, T_IDLE, 1, 0, 0, 1, 2'b00, 32'h0,    8'd2);
    add(32'h0000_0000, T_IDLE, 1, 0, 0, 1, 2'b00, 32'h0,    8'd2);
`endif

    // Reset state, then release between edges so the very next edge can accept.
    next_cycle();
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 8'd0);
    chk("yy_haddr copy", yy_haddr, cpu_haddr);
    rst_b = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cpu_haddr  = vecs[i].addr;
      cpu_htrans = vecs[i].trans;
      mmc_hready = vecs[i].mmc_rdy;
      cpu_hwdata = vecs[i].addr ^ 32'h5A5A_5A5A;
      cpu_hwrite = vecs[i].addr[4];
      #2;
      $display("row %0d addr %h htrans %b hready %b hresp %b hrdata %h cnt %0d",
               i, cpu_haddr, cpu_htrans, cpu_hready, cpu_hresp, cpu_hrdata, cnt);
      chk_all($sformatf("row%0d", i), vecs[i].e_msel, vecs[i].e_psel, vecs[i].e_rdy,
              vecs[i].e_resp, vecs[i].e_rdata, vecs[i].e_cnt);
      chk($sformatf("row%0d yy_htrans", i), {30'h0, yy_htrans}, {30'h0, vecs[i].trans});
      chk($sformatf("row%0d yy_hwdata", i), yy_hwdata, vecs[i].addr ^ 32'h5A5A_5A5A);
      next_cycle();
    end
    mmc_hready = 1'b1;

    // Continuous unmapped NONSEQ traffic: counter must stick at FF, never wrap.
    cpu_haddr = 32'h8000_0000; cpu_htrans = T_NS;
    for (int i = 0; i < 700; i++) next_cycle();
    #2;
    $display("saturation run cnt %0d", cnt);
    chk("sat cnt", {24'h0, cnt}, 32'h0000_00FF);
    chk("sat mmc_hsel", {31'h0, mmc_hsel}, 32'h0);
    chk("sat per_hsel", {31'h0, per_hsel}, 32'h0);

    // Return to NONE, issue one unmapped transfer, reset in the following data phase.
    cpu_htrans = T_IDLE;
    for (int i = 0; i < 3; i++) next_cycle();
    cpu_htrans = T_NS;
    next_cycle();
    cpu_htrans = T_IDLE;
    #2;
`ifdef IAHB_DEC_ERR_RESP_EN
    chk("err1 hready", {31'h0, cpu_hready}, 32'h0);
    chk("err1 hresp", {30'h0, cpu_hresp}, 32'h1);
`else
    chk("def hready", {31'h0, cpu_hready}, 32'h1);
    chk("def hresp", {30'h0, cpu_hresp}, 32'h0);
`endif
    rst_b = 1'b0;
    #1;
    $display("async reset mid data phase hready %b cnt %0d", cpu_hready, cnt);
    chk_all("midreset", 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 8'd0);

    // First edge after release must accept a memory read.
    cpu_haddr = 32'h0000_0010; cpu_htrans = T_NS;
    #2;
    rst_b = 1'b1;
    #1;
    chk("postrst mmc_hsel", {31'h0, mmc_hsel}, 32'h1);
    next_cycle();
    cpu_htrans = T_IDLE;
    #1;
    $display("post reset read hrdata %h", cpu_hrdata);
    chk_all("postrst data", 1'b0, 1'b0, 1'b1, 2'b00, MEM_DATA, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
